// File: rtl/fifo_line_unpacker.sv
// Pops wide lines from a show-ahead FIFO and streams them out as narrow
// words, lane 0 first, on a valid/ready interface with no inter-line bubble.
module fifo_line_unpacker #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32,
  localparam int LANES    = IN_WIDTH / OUT_WIDTH,
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [LANE_W-1:0]    out_lane,
  output logic [CNT_WIDTH-1:0] lines_done
);

  logic [IN_WIDTH-1:0]  line_q, line_d;
  logic                 line_valid_q, line_valid_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [CNT_WIDTH-1:0] lines_done_q, lines_done_d;

  logic [OUT_WIDTH-1:0] lane_words [LANES];
  logic                 is_last_lane;
  logic                 accept;
  logic                 last_accept;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_words[gi] = line_q[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  assign is_last_lane = (lane_q == LANE_W'(LANES - 1));

  // Outputs are gated by reset so nothing leaks out while reset is held,
  // including the cycle in which reset is first asserted mid-line.
  assign out_valid   = reset_n & line_valid_q;
  assign out_last    = out_valid & is_last_lane;
  assign out_data    = out_valid ? lane_words[lane_q] : '0;
  assign out_lane    = lane_q;
  assign lines_done  = lines_done_q;

  assign accept      = out_valid & out_ready;
  assign last_accept = accept & is_last_lane;
  assign fifo_rdreq  = reset_n & ~fifo_empty & (~line_valid_q | last_accept);

  always_comb begin
    line_d       = line_q;
    line_valid_d = line_valid_q;
    lane_d       = lane_q;
    lines_done_d = lines_done_q;

    if (fifo_rdreq) begin
      line_d       = fifo_q;
      line_valid_d = 1'b1;
      lane_d       = '0;
    end else if (last_accept) begin
      line_valid_d = 1'b0;
      lane_d       = '0;
    end else if (accept) begin
      lane_d       = lane_q + LANE_W'(1);
    end

    if (last_accept) begin
      lines_done_d = lines_done_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      line_q       <= '0;
      line_valid_q <= 1'b0;
      lane_q       <= '0;
      lines_done_q <= '0;
    end else begin
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
      lane_q       <= lane_d;
      lines_done_q <= lines_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_line_unpacker.sv
// Directed bench: the initial block plays the show-ahead FIFO and downstream
// sink step by step and compares each DUT output against hand-derived values.
module tb_fifo_line_unpacker;

  logic          clock;
  logic          reset_n;
  logic [511:0]  fifo_q;
  logic          fifo_empty;
  logic          fifo_rdreq;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [2:0]    out_lane;
  logic [31:0]   lines_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [511:0] fifo_lines [$];

  fifo_line_unpacker dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_lane   (out_lane),
    .lines_done (lines_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present the FIFO head (random junk when empty) and let logic settle.
  task automatic refresh();
    fifo_empty = (fifo_lines.size() == 0);
    if (fifo_empty) begin
      for (int k = 0; k < 16; k++) fifo_q[k*32 +: 32] = $urandom;
    end else begin
      fifo_q = fifo_lines[0];
    end
    #1;
  endtask

  // Advance one clock; the model FIFO pops if rdreq was high at the edge.
  task automatic cycle();
    logic pop;
    pop = fifo_rdreq;
    @(posedge clock);
    #1;
    if (pop) void'(fifo_lines.pop_front());
    refresh();
  endtask

  int exp_lane;
  int c;

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    refresh();

    // Reset then idle
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_valid", out_valid, 0);
    chk("rst_rdreq", fifo_rdreq, 0);
    chk("rst_lines", lines_done, 0);
    chk("rst_lane", out_lane, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    $display("step reset: valid=%0b rdreq=%0b lines=%0d", out_valid, fifo_rdreq, lines_done);

    // Single line, out_ready high
    reset_n   = 1'b1;
    out_ready = 1'b1;
    fifo_lines.push_back(mk_line(64'd1));
    refresh();
    chk("single_pop", fifo_rdreq, 1);
    cycle();
    for (int k = 0; k < 8; k++) begin
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 64'(k + 1));
      chk("single_last", out_last, (k == 7) ? 1 : 0);
      chk("single_nopop", fifo_rdreq, 0);
      $display("single word %0d: data=%0h last=%0b", k, out_data, out_last);
      cycle();
    end
    chk("single_drop", out_valid, 0);
    chk("single_lines", lines_done, 1);

    // Three back-to-back lines
    fifo_lines.push_back(mk_line(64'h10));
    fifo_lines.push_back(mk_line(64'h20));
    fifo_lines.push_back(mk_line(64'h30));
    refresh();
    for (c = 0; c <= 24; c++) begin
      chk("b2b_rdreq", fifo_rdreq, (c < 24 && c % 8 == 0) ? 1 : 0);
      if (c >= 1) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", out_data, 64'(16 * (1 + (c - 1) / 8) + (c - 1) % 8));
        chk("b2b_last", out_last, ((c - 1) % 8 == 7) ? 1 : 0);
        $display("b2b cycle %0d: data=%0h rdreq=%0b", c, out_data, fifo_rdreq);
      end
      cycle();
    end
    chk("b2b_drop", out_valid, 0);
    chk("b2b_lines", lines_done, 4);

    // Back-pressure with a second line waiting behind the held one
    fifo_lines.push_back(mk_line(64'h40));
    fifo_lines.push_back(mk_line(64'h50));
    refresh();
    chk("bp_pop", fifo_rdreq, 1);
    cycle();
    exp_lane = 0;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3 == 0);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 64'(64 + exp_lane));
      chk("bp_lane", out_lane, 64'(exp_lane));
      chk("bp_last", out_last, (exp_lane == 7) ? 1 : 0);
      chk("bp_rdreq", fifo_rdreq, (out_ready && exp_lane == 7) ? 1 : 0);
      $display("bp step %0d: ready=%0b lane=%0d data=%0h", i, out_ready, out_lane, out_data);
      if (out_ready) exp_lane++;
      cycle();
      if (exp_lane == 8) break;
    end
    chk("bp_done", exp_lane, 8);

    // Following line starts with no bubble, then FIFO empty at its end
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("tail_valid", out_valid, 1);
      chk("tail_data", out_data, 64'(80 + k));
      $display("tail word %0d: data=%0h", k, out_data);
      cycle();
    end
    chk("empty_drop", out_valid, 0);
    chk("empty_lines", lines_done, 6);
    cycle();
    chk("idle_rdreq", fifo_rdreq, 0);
    chk("idle_valid", out_valid, 0);

    // Late push: pop in the same cycle, lane 0 valid the next
    fifo_lines.push_back(mk_line(64'h60));
    refresh();
    chk("late_pop", fifo_rdreq, 1);
    cycle();
    chk("late_valid", out_valid, 1);
    chk("late_data", out_data, 64'h60);
    chk("late_lane", out_lane, 0);
    $display("late push: data=%0h lane=%0d", out_data, out_lane);

    // Reset mid-line after lanes 0..3 are accepted
    fifo_lines.push_back(mk_line(64'h70));
    refresh();
    for (int k = 0; k < 4; k++) begin
      chk("mid_nopop", fifo_rdreq, 0);
      cycle();
    end
    chk("mid_lane", out_lane, 4);
    chk("mid_data", out_data, 64'h64);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdreq", fifo_rdreq, 0);
    chk("mid_rst_gate", out_valid, 0);
    cycle();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_lane", out_lane, 0);
    chk("mid_rst_lines", lines_done, 0);
    chk("mid_rst_rdreq2", fifo_rdreq, 0);
    $display("reset mid-line: valid=%0b lane=%0d lines=%0d", out_valid, out_lane, lines_done);
    reset_n = 1'b1;
    #1;
    chk("post_rst_pop", fifo_rdreq, 1);
    cycle();
    for (int k = 0; k < 8; k++) begin
      chk("post_valid", out_valid, 1);
      chk("post_lane", out_lane, 64'(k));
      chk("post_data", out_data, 64'(112 + k));
      $display("post-reset word %0d: data=%0h", k, out_data);
      cycle();
    end
    chk("post_drop", out_valid, 0);
    chk("post_lines", lines_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_line_unpacker.md
Name: fifo_line_unpacker

Overview:
- Downstream consumer of the 512-bit show-ahead FIFO in the dnnweaver data path.
- Pops one wide line at a time from the FIFO and serialises it, least-significant lane first, into narrow words on a valid/ready stream feeding the PE-array input.
- Sustains one word per cycle with no bubble between consecutive lines.

Parameters:
- IN_WIDTH, 512, width of a FIFO line (matches FIFO WIDTH).
- OUT_WIDTH, 64, width of an output word; IN_WIDTH must be an integer multiple of OUT_WIDTH.
- LANES, IN_WIDTH/OUT_WIDTH, derived (localparam): words per line.
- CNT_WIDTH, 32, width of the lines-consumed counter.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- fifo_q  input  IN_WIDTH  FIFO head data, valid whenever fifo_empty is low (show-ahead).
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdreq  output  1  FIFO dequeue strobe, combinational.
- out_data  output  OUT_WIDTH  current word = line_reg[lane*OUT_WIDTH +: OUT_WIDTH].
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word this cycle.
- out_last  output  1  high with out_valid when lane == LANES-1.
- out_lane  output  clog2(LANES) (min 1)  current lane index.
- lines_done  output  CNT_WIDTH  count of fully emitted lines.

Behaviour:
- State: line_reg (IN_WIDTH), line_valid (1), lane (clog2(LANES)), lines_done.
- Reset (reset_n low at clock edge): line_valid=0, lane=0, lines_done=0, line_reg=0. During reset cycles, fifo_rdreq is forced 0, and out_valid, out_last and out_data are 0.
- Accept: a word is accepted when out_valid && out_ready.
- last_accept = accept && lane==LANES-1.
- fifo_rdreq = reset_n && !fifo_empty && (!line_valid || last_accept). Never asserted when fifo_empty=1.
- Load (fifo_rdreq=1): line_reg<=fifo_q, lane<=0, line_valid<=1.
- Accept without last: lane<=lane+1.
- last_accept without load: line_valid<=0, lane<=0.
- lines_done increments by 1 on every last_accept. It wraps modulo 2^CNT_WIDTH.
- out_valid = line_valid. out_data and out_last hold stable while out_valid && !out_ready (standard valid/ready rule; valid never drops without an accept).
- Latency: a line arriving in an empty FIFO gives fifo_empty low in cycle N, the pop in cycle N, and lane-0 out_valid in cycle N+1.
- Throughput: when last_accept and the FIFO is non-empty in the same cycle, the next line loads in that cycle, so lane 0 of the next line is valid on the following cycle with no idle cycle.
- Back-pressure: out_ready low freezes lane and line_reg. No pop occurs while a line is held and not finishing.
- LANES==1: every accept is last_accept, out_last is constantly high when valid, and the block degenerates to a 1-entry pipeline register.
- Reset mid-line: the held line is discarded, lane returns to 0, and no FIFO pop occurs in the reset cycle.
- Upstream fifo_q changes while line_valid=1 have no effect on out_data.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles with fifo_empty=1 -> out_valid=0, fifo_rdreq=0, lines_done=0, out_lane=0.
- Single line, out_ready=1: fifo_q=0x…0007_…_0001 (lane k = k+1 in each 64-bit lane), fifo_empty low for one pop -> fifo_rdreq pulses 1 cycle; out_data=1,2,…,8 on 8 consecutive cycles; out_last only on the 8th; lines_done 0→1.
- Back-to-back lines: FIFO holds 3 lines, out_ready=1 -> exactly 24 consecutive valid cycles, fifo_rdreq high on cycles 0, 8 and 16 relative to the first pop, lines_done=3.
- Back-pressure: out_ready toggles 1,0,0,1,… during a line -> out_data and out_lane are stable across low-ready cycles, no extra fifo_rdreq, all 8 words are delivered in order.
- Empty at line end: one line in the FIFO, fifo_empty=1 at the last accept -> out_valid drops the next cycle. A later push gives a pop in the same cycle and lane 0 valid the cycle after.
- Reset mid-line: assert reset_n=0 after lane 3 is accepted -> the next cycle shows out_valid=0, lane=0, lines_done unchanged at reset value 0. After reset release, the next FIFO line is emitted from lane 0.
